// File: rtl/msx_sdram_arbiter_if.sv
// Bus bundle between the MSX slot decoder / flash emulation and the SDRAM controller port.
// master = the arbiter, slave = the CPU, flash and controller side.
interface msx_sdram_arbiter_if #(
  parameter int ADDR_W = 27
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_rnw;
  logic              sdram_ce;
  logic [7:0]        ram_dout;
  logic              cpu_wait;

  logic [ADDR_W-1:0] flash_addr;
  logic [7:0]        flash_din;
  logic              flash_req;
  logic              flash_ready;
  logic              flash_done;

  logic [ADDR_W-1:0] sdr_addr;
  logic [7:0]        sdr_din;
  logic              sdr_we;
  logic              sdr_req;
  logic              sdr_done;
  logic [7:0]        sdr_dout;

  modport master (
    input  ram_addr, ram_din, ram_rnw, sdram_ce,
    output ram_dout, cpu_wait,
    input  flash_addr, flash_din, flash_req,
    output flash_ready, flash_done,
    output sdr_addr, sdr_din, sdr_we, sdr_req,
    input  sdr_done, sdr_dout
  );

  modport slave (
    output ram_addr, ram_din, ram_rnw, sdram_ce,
    input  ram_dout, cpu_wait,
    output flash_addr, flash_din, flash_req,
    input  flash_ready, flash_done,
    input  sdr_addr, sdr_din, sdr_we, sdr_req,
    output sdr_done, sdr_dout
  );
endinterface

// File: rtl/msx_sdram_arbiter.sv
// Merges the CPU memory port and the flash-programming port onto one SDRAM controller port.
// CPU has priority; a pending flash write is forced through after STARVE_LIMIT CPU grants.
//
// state        | meaning
// S_IDLE       | no access outstanding; arbitrates CPU vs pending flash write
// S_CPU_BUSY   | CPU access issued, waiting for sdr_done
// S_FLASH_BUSY | flash write issued, waiting for sdr_done
module msx_sdram_arbiter #(
  parameter int ADDR_W       = 27,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  msx_sdram_arbiter_if.master bus
);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_CPU_BUSY, S_FLASH_BUSY} state_t;

  state_t            state, state_nxt;
  logic [7:0]        starve, starve_nxt;
  logic              cpu_served, cpu_served_nxt;
  logic              flash_pend, flash_pend_nxt;
  logic [ADDR_W-1:0] fl_addr, fl_addr_nxt;
  logic [7:0]        fl_din, fl_din_nxt;
  logic [ADDR_W-1:0] cpu_addr, cpu_addr_nxt;
  logic              cpu_rnw, cpu_rnw_nxt;
  logic [ADDR_W-1:0] sdr_addr, sdr_addr_nxt;
  logic [7:0]        sdr_din, sdr_din_nxt;
  logic              sdr_we, sdr_we_nxt;
  logic              sdr_req, sdr_req_nxt;
  logic [7:0]        ram_dout, ram_dout_nxt;
  logic              flash_done, flash_done_nxt;

  logic cpu_mismatch, cpu_new, flash_force;

  // A served flag only counts while the CPU still presents the access it was served for,
  // so a new address under a held sdram_ce is seen as a new request in the same cycle.
  assign cpu_mismatch = ~bus.sdram_ce | (bus.ram_addr != cpu_addr) | (bus.ram_rnw != cpu_rnw);
  assign cpu_new      = bus.sdram_ce & ~(cpu_served & ~cpu_mismatch);
  assign flash_force  = flash_pend & (starve == STARVE_MAX);

  assign bus.cpu_wait    = reset & (cpu_new | (state == S_CPU_BUSY));
  assign bus.flash_ready = ~flash_pend;
  assign bus.flash_done  = flash_done;
  assign bus.ram_dout    = ram_dout;
  assign bus.sdr_addr    = sdr_addr;
  assign bus.sdr_din     = sdr_din;
  assign bus.sdr_we      = sdr_we;
  assign bus.sdr_req     = sdr_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      starve     <= '0;
      cpu_served <= 1'b0;
      flash_pend <= 1'b0;
      fl_addr    <= '0;
      fl_din     <= '0;
      cpu_addr   <= '0;
      cpu_rnw    <= 1'b0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_we     <= 1'b0;
      sdr_req    <= 1'b0;
      ram_dout   <= '0;
      flash_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve     <= starve_nxt;
      cpu_served <= cpu_served_nxt;
      flash_pend <= flash_pend_nxt;
      fl_addr    <= fl_addr_nxt;
      fl_din     <= fl_din_nxt;
      cpu_addr   <= cpu_addr_nxt;
      cpu_rnw    <= cpu_rnw_nxt;
      sdr_addr   <= sdr_addr_nxt;
      sdr_din    <= sdr_din_nxt;
      sdr_we     <= sdr_we_nxt;
      sdr_req    <= sdr_req_nxt;
      ram_dout   <= ram_dout_nxt;
      flash_done <= flash_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_nxt     = starve;
    cpu_served_nxt = cpu_served & ~cpu_mismatch;
    flash_pend_nxt = flash_pend;
    fl_addr_nxt    = fl_addr;
    fl_din_nxt     = fl_din;
    cpu_addr_nxt   = cpu_addr;
    cpu_rnw_nxt    = cpu_rnw;
    sdr_addr_nxt   = sdr_addr;
    sdr_din_nxt    = sdr_din;
    sdr_we_nxt     = sdr_we;
    sdr_req_nxt    = sdr_req;
    ram_dout_nxt   = ram_dout;
    flash_done_nxt = 1'b0;

    // A second flash_req while one is pending is dropped, not queued.
    if (bus.flash_req && !flash_pend) begin
      flash_pend_nxt = 1'b1;
      fl_addr_nxt    = bus.flash_addr;
      fl_din_nxt     = bus.flash_din;
    end

    case (state)
      S_IDLE: begin
        if (cpu_new && !flash_force) begin
          sdr_addr_nxt = bus.ram_addr;
          sdr_din_nxt  = bus.ram_din;
          sdr_we_nxt   = ~bus.ram_rnw;
          sdr_req_nxt  = 1'b1;
          cpu_addr_nxt = bus.ram_addr;
          cpu_rnw_nxt  = bus.ram_rnw;
          state_nxt    = S_CPU_BUSY;
          if (flash_pend && (starve < STARVE_MAX)) starve_nxt = starve + 8'd1;
        end else if (flash_pend) begin
          sdr_addr_nxt = fl_addr;
          sdr_din_nxt  = fl_din;
          sdr_we_nxt   = 1'b1;
          sdr_req_nxt  = 1'b1;
          starve_nxt   = '0;
          state_nxt    = S_FLASH_BUSY;
        end
      end
      S_CPU_BUSY: begin
        if (bus.sdr_done) begin
          sdr_req_nxt = 1'b0;
          if (cpu_rnw) ram_dout_nxt = bus.sdr_dout;
          // An aborted access still completes but leaves the CPU unserved.
          if (!cpu_mismatch) cpu_served_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FLASH_BUSY: begin
        if (bus.sdr_done) begin
          sdr_req_nxt    = 1'b0;
          flash_pend_nxt = 1'b0;
          flash_done_nxt = 1'b1;
          state_nxt      = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// Directed bench for msx_sdram_arbiter: CPU reads/writes, flash writes, arbitration,
// starvation limit and asynchronous reset, against a 4-clock SDRAM controller model.
module tb_msx_sdram_arbiter;
  localparam int AW = 27;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          we;
  } acc_t;

  logic clk;
  logic reset;
  logic resp_done;
  logic stray_done;
  logic [7:0] rd_data;
  int   resp_cnt;

  acc_t acc_q[$];
  logic prev_req;
  logic prev_fd;
  int   stab_err;
  int   fd_long;
  int   fd_qsize;

  int n_checks;
  int n_errors;
  int base;

  msx_sdram_arbiter_if #(.ADDR_W(AW)) bus ();

  msx_sdram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sdr_done = resp_done | stray_done;
  assign bus.sdr_dout = rd_data;

  // Controller model: sdr_done pulses 4 clocks after sdr_req rises.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_cnt  <= 0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (bus.sdr_req && !resp_done) begin
        if (resp_cnt == 3) begin
          resp_done <= 1'b1;
          resp_cnt  <= 0;
        end else begin
          resp_cnt <= resp_cnt + 1;
        end
      end
    end
  end

  // Access log, sdr_* stability while requested, flash_done pulse width.
  initial begin
    prev_req = 1'b0;
    prev_fd  = 1'b0;
    stab_err = 0;
    fd_long  = 0;
    fd_qsize = 0;
  end

  always @(negedge clk) begin
    if (bus.sdr_req && !prev_req)
      acc_q.push_back('{addr: bus.sdr_addr, din: bus.sdr_din, we: bus.sdr_we});
    else if (bus.sdr_req && acc_q.size() > 0) begin
      if (bus.sdr_addr !== acc_q[$].addr || bus.sdr_din !== acc_q[$].din || bus.sdr_we !== acc_q[$].we)
        stab_err <= stab_err + 1;
    end
    if (bus.flash_done) begin
      if (prev_fd) fd_long <= fd_long + 1;
      else         fd_qsize <= acc_q.size();
    end
    prev_req <= bus.sdr_req;
    prev_fd  <= bus.flash_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // sel: 0 = sdr_done high, 1 = flash_done high, 2 = cpu_wait low
  task automatic wait_for(input int sel, input string tag);
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      case (sel)
        0:       hit = bus.sdr_done;
        1:       hit = bus.flash_done;
        default: hit = ~bus.cpu_wait;
      endcase
      if (!hit) begin
        @(negedge clk);
        n++;
      end
    end
    if (!hit) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b0;
    stray_done     = 1'b0;
    rd_data        = 8'h00;
    bus.ram_addr   = '0;
    bus.ram_din    = '0;
    bus.ram_rnw    = 1'b1;
    bus.sdram_ce   = 1'b0;
    bus.flash_addr = '0;
    bus.flash_din  = '0;
    bus.flash_req  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sdr_req", bus.sdr_req, 0);
    chk("rst_cpu_wait", bus.cpu_wait, 0);
    chk("rst_flash_ready", bus.flash_ready, 1);
    chk("rst_flash_done", bus.flash_done, 0);
    chk("rst_ram_dout", bus.ram_dout, 0);
    chk("rst_sdr_addr", bus.sdr_addr, 0);
    chk("rst_sdr_we", bus.sdr_we, 0);
    reset = 1'b1;
    @(negedge clk);

    // CPU read held for 20 clocks
    base         = acc_q.size();
    rd_data      = 8'hA5;
    bus.ram_addr = 27'h0012345;
    bus.ram_rnw  = 1'b1;
    bus.sdram_ce = 1'b1;
    #1 chk("rd_wait_comb", bus.cpu_wait, 1);
    @(negedge clk);
    chk("rd_req_latency", bus.sdr_req, 1);
    chk("rd_we", bus.sdr_we, 0);
    wait_for(0, "rd_done_timeout");
    chk("rd_dout_before", bus.ram_dout, 8'h00);
    chk("rd_wait_at_done", bus.cpu_wait, 1);
    @(negedge clk);
    chk("rd_dout", bus.ram_dout, 8'hA5);
    chk("rd_wait_low", bus.cpu_wait, 0);
    repeat (14) @(negedge clk);
    chk("rd_wait_held", bus.cpu_wait, 0);
    chk("rd_count", acc_q.size() - base, 1);
    chk("rd_addr", acc_q[base].addr, 27'h0012345);
    bus.sdram_ce = 1'b0;
    @(negedge clk);

    // CPU write, then address change under held ce
    base         = acc_q.size();
    bus.ram_addr = 27'h100;
    bus.ram_din  = 8'h3C;
    bus.ram_rnw  = 1'b0;
    bus.sdram_ce = 1'b1;
    @(negedge clk);
    wait_for(0, "wr0_done_timeout");
    @(negedge clk);
    chk("wr0_wait_low", bus.cpu_wait, 0);
    bus.ram_addr = 27'h101;
    @(negedge clk);
    wait_for(0, "wr1_done_timeout");
    repeat (4) @(negedge clk);
    chk("wr_count", acc_q.size() - base, 2);
    chk("wr0_addr", acc_q[base].addr, 27'h100);
    chk("wr0_we", acc_q[base].we, 1);
    chk("wr0_din", acc_q[base].din, 8'h3C);
    chk("wr1_addr", acc_q[base+1].addr, 27'h101);
    chk("wr1_we", acc_q[base+1].we, 1);
    chk("wr_dout_kept", bus.ram_dout, 8'hA5);
    bus.sdram_ce = 1'b0;
    bus.ram_rnw  = 1'b1;
    @(negedge clk);

    // Flash write, plus an ignored second request while pending
    base           = acc_q.size();
    bus.flash_addr = 27'h0400000;
    bus.flash_din  = 8'hFF;
    bus.flash_req  = 1'b1;
    @(negedge clk);
    bus.flash_req  = 1'b0;
    chk("fl_ready_low", bus.flash_ready, 0);
    bus.flash_addr = 27'h0000007;
    bus.flash_din  = 8'h00;
    bus.flash_req  = 1'b1;
    @(negedge clk);
    bus.flash_req  = 1'b0;
    chk("fl_violation_flagged", bus.flash_ready, 0);
    wait_for(1, "fl_done_timeout");
    @(negedge clk);
    chk("fl_done_pulse", bus.flash_done, 0);
    chk("fl_ready_high", bus.flash_ready, 1);
    repeat (6) @(negedge clk);
    chk("fl_count", acc_q.size() - base, 1);
    chk("fl_addr", acc_q[base].addr, 27'h0400000);
    chk("fl_din", acc_q[base].din, 8'hFF);
    chk("fl_we", acc_q[base].we, 1);

    // Simultaneous CPU read and flash request: CPU first
    base           = acc_q.size();
    rd_data        = 8'h3B;
    bus.ram_addr   = 27'h200;
    bus.ram_rnw    = 1'b1;
    bus.sdram_ce   = 1'b1;
    bus.flash_addr = 27'h500;
    bus.flash_din  = 8'h11;
    bus.flash_req  = 1'b1;
    @(negedge clk);
    bus.flash_req  = 1'b0;
    wait_for(1, "sim_done_timeout");
    repeat (2) @(negedge clk);
    chk("sim_order_cpu", acc_q[base].addr, 27'h200);
    chk("sim_cpu_we", acc_q[base].we, 0);
    chk("sim_order_flash", acc_q[base+1].addr, 27'h500);
    chk("sim_flash_we", acc_q[base+1].we, 1);
    chk("sim_done_after_flash", fd_qsize - base, 2);
    chk("sim_dout", bus.ram_dout, 8'h3B);
    bus.sdram_ce = 1'b0;
    @(negedge clk);

    // Starvation: flash pending behind continuous distinct CPU reads
    base           = acc_q.size();
    rd_data        = 8'h77;
    bus.ram_addr   = 27'h1000;
    bus.sdram_ce   = 1'b1;
    @(negedge clk);
    bus.flash_addr = 27'h600;
    bus.flash_din  = 8'h22;
    bus.flash_req  = 1'b1;
    @(negedge clk);
    bus.flash_req  = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      wait_for(2, "stv_cpu_timeout");
      bus.ram_addr = 27'h1000 + AW'(i);
      @(negedge clk);
    end
    wait_for(2, "stv_last_timeout");
    repeat (2) @(negedge clk);
    chk("stv_count", acc_q.size() - base, 11);
    chk("stv_8th_pending_cpu", acc_q[base+8].we, 0);
    chk("stv_flash_we", acc_q[base+9].we, 1);
    chk("stv_flash_addr", acc_q[base+9].addr, 27'h600);
    chk("stv_flash_din", acc_q[base+9].din, 8'h22);
    chk("stv_cpu9_addr", acc_q[base+10].addr, 27'h1009);
    chk("stv_cpu9_after_done", fd_qsize - base, 10);
    bus.sdram_ce = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a CPU access
    bus.ram_addr = 27'h300;
    bus.sdram_ce = 1'b1;
    @(negedge clk);
    chk("ar_busy", bus.sdr_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_sdr_req", bus.sdr_req, 0);
    chk("ar_cpu_wait", bus.cpu_wait, 0);
    chk("ar_flash_ready", bus.flash_ready, 1);
    chk("ar_ram_dout", bus.ram_dout, 0);
    bus.sdram_ce = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_data    = 8'hEE;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray_ram_dout", bus.ram_dout, 0);
    chk("stray_flash_done", bus.flash_done, 0);
    chk("stray_sdr_req", bus.sdr_req, 0);
    rd_data      = 8'h5C;
    bus.ram_addr = 27'h301;
    bus.sdram_ce = 1'b1;
    @(negedge clk);
    chk("post_rst_req", bus.sdr_req, 1);
    chk("post_rst_addr", bus.sdr_addr, 27'h301);
    wait_for(0, "post_rst_timeout");
    @(negedge clk);
    chk("post_rst_dout", bus.ram_dout, 8'h5C);
    chk("post_rst_wait", bus.cpu_wait, 0);
    bus.sdram_ce = 1'b0;
    repeat (3) @(negedge clk);

    chk("sdr_stable", stab_err, 0);
    chk("flash_done_width", fd_long, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
